// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Default sizes, FSM state type and modulo index increment.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DSIZE     = 8;
  localparam int DEF_MAX_BURST = 4;

  // Explicit wrap so non-power-of-two requester counts work.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit at or after
// rr_ptr, wrapping modulo NREQ. Purely combinational.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int          c;
  logic [IW-1:0] ci;

  // Scan offsets 0..NREQ-1 from rr_ptr; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    ci    = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      ci = IW'(c);
      if (!valid && req[ci]) begin
        valid = 1'b1;
        idx   = ci;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked sharing of the async FIFO write port.
// One dead cycle per ownership change; never writes while wfull.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DSIZE     = DEF_DSIZE,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic                  wfull,
  output logic [NREQ-1:0]       gnt,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy,
  output logic [IW-1:0]         owner
);

  arb_state_t    state, state_n;
  logic [IW-1:0] rr_ptr, rr_n;
  logic [IW-1:0] owner_n;
  logic [CW-1:0] burst_cnt, cnt_n;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          own_req;
  logic          accept;
  logic          last;
  logic [IW-1:0] nxt_owner;

  logic [DSIZE-1:0] slot [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot[i] = req_data[i*DSIZE +: DSIZE];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign own_req   = req[owner];
  assign accept    = (state == BURST) && own_req && !wfull;
  assign last      = (burst_cnt == CW'(MAX_BURST - 1));
  assign nxt_owner = IW'(next_idx(int'(owner), NREQ));

  // State, ownership and burst counter registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      owner     <= owner_n;
      burst_cnt <= cnt_n;
    end
  end

  // Next state: pick in IDLE, count/stall/release in BURST.
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = owner;
    cnt_n   = burst_cnt;
    unique case (state)
      IDLE: begin
        if (pick_valid && !wfull) begin
          state_n = BURST;
          owner_n = pick_idx;
          cnt_n   = '0;
        end
      end
      BURST: begin
        if (!own_req) begin
          state_n = IDLE;
          rr_n    = nxt_owner;
        end else if (!wfull) begin
          cnt_n = burst_cnt + CW'(1);
          if (last) begin
            state_n = IDLE;
            rr_n    = nxt_owner;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: zero-latency grant/write, all forced low in reset.
  always_comb begin
    gnt   = '0;
    winc  = 1'b0;
    wdata = '0;
    busy  = (state == BURST);
    if (!wrst && accept) begin
      gnt[owner] = 1'b1;
      winc       = 1'b1;
      wdata      = slot[owner];
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: ownership-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fifo_write_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int MAXB  = 4;
  localparam int BIG   = 1000;

  logic                  wclk = 1'b0;
  logic                  wrst = 1'b1;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;
  logic [1:0]            owner;

  int         remaining [NREQ];
  logic [7:0] dat [NREQ];

  always #5 wclk = ~wclk;

  always_comb begin
    req      = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (remaining[i] > 0);
      req_data[i*DSIZE +: DSIZE] = dat[i];
    end
  end

  fifo_write_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAXB)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req      (req),
    .req_data (req_data),
    .wfull    (wfull),
    .gnt      (gnt),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy),
    .owner    (owner)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    int         who;
    logic [7:0] d;
  } wr_t;

  wr_t log_q [$];

  // Ownership-level model: who holds the port and for how long.
  bit m_act = 0;
  int m_own = 0;
  int m_used = 0;
  int m_ptr = 0;

  always @(posedge wclk) begin
    cyc++;
    if (wrst) begin
      m_act = 0; m_own = 0; m_used = 0; m_ptr = 0;
    end else if (!m_act) begin
      if (req != 0 && !wfull) begin
        bit found;
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && req[(m_ptr + k) % NREQ]) begin
            found = 1;
            m_own = (m_ptr + k) % NREQ;
          end
        end
        m_act  = 1;
        m_used = 0;
      end
    end else if (!req[m_own]) begin
      m_act = 0;
      m_ptr = (m_own + 1) % NREQ;
    end else if (!wfull) begin
      m_used++;
      if (m_used == MAXB) begin
        m_act = 0;
        m_ptr = (m_own + 1) % NREQ;
      end
    end
  end

  bit              check_en = 0;
  logic [NREQ-1:0] gnt_seen = '0;
  logic [NREQ-1:0] eg;
  logic [7:0]      ed;
  int              streak = 0;
  int              who;

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge wclk) begin
    if (check_en) begin
      eg = '0;
      ed = '0;
      if (!wrst && m_act && req[m_own] && !wfull) begin
        eg[m_own] = 1'b1;
        ed = dat[m_own];
      end
      check("gnt", gnt, eg);
      check("winc", winc, |eg);
      check("wdata", wdata, ed);
      check("busy", busy, m_act);
      check("owner", owner, m_own);
      check("gnt_onehot0", $onehot0(gnt), 1);
      check("winc_eq_or_gnt", winc, |gnt);
      check("winc_while_full", winc & wfull, 0);
      if (!m_act) streak = 0;
      if (winc) begin
        who = 0;
        for (int i = 0; i < NREQ; i++)
          if (gnt[i]) who = i;
        log_q.push_back('{cyc, who, wdata});
        streak++;
        check("burst_len_ok", streak <= MAXB, 1);
      end
    end
    gnt_seen = gnt;
  end

  // Requesters consume one word per granted edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge wclk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_seen[i]) begin
          remaining[i]--;
          dat[i] = dat[i] + 8'd1;
        end
      end
    end
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    step(1);
    wrst = 1'b0;
    log_q.delete();
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (log_q.size() < n && t < 60) begin
      step(1);
      t++;
    end
    check("wait_writes_reached", log_q.size() >= n, 1);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
  endtask

  int         rel;
  int         c_in;
  logic [7:0] d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      remaining[i] = BIG;
      dat[i] = 8'(i * 16);
    end

    // Reset held 3 cycles under full request load.
    @(posedge wclk);
    #1;
    check_en = 1;
    step(2);
    check("reset_no_writes", log_q.size(), 0);
    wrst = 1'b0;
    rel = cyc;

    // Full contention straight out of reset.
    step(20);
    check("cont_writes_20cyc", log_q.size(), 16);
    check("cont_first_cyc", log_q[0].cyc - rel, 1);
    check("cont_w0_who", log_q[0].who, 0);
    check("cont_w0_data", log_q[0].d, 8'h00);
    check("cont_w4_who", log_q[4].who, 1);
    check("cont_w4_data", log_q[4].d, 8'h10);
    check("cont_w8_who", log_q[8].who, 2);
    check("cont_w15_who", log_q[15].who, 3);
    step(5);
    check("cont_w16_who", log_q[16].who, 0);
    check("cont_w16_data", log_q[16].d, 8'h04);

    // Single requester, with wfull held in IDLE first.
    clear_reqs();
    remaining[2] = 10;
    dat[2] = 8'hA0;
    do_reset();
    wfull = 1'b1;
    step(2);
    check("idle_full_no_pick", busy, 0);
    check("idle_full_no_write", log_q.size(), 0);
    wfull = 1'b0;
    step(20);
    check("single_count", log_q.size(), 10);
    for (int k = 0; k < 10 && k < log_q.size(); k++) begin
      check("single_who", log_q[k].who, 2);
      check("single_data", log_q[k].d, 8'hA0 + 8'(k));
    end
    if (log_q.size() >= 5) begin
      check("single_burst_span", log_q[3].cyc - log_q[0].cyc, 3);
      check("single_dead_cycle", log_q[4].cyc - log_q[3].cyc, 2);
    end
    check("single_owner_kept", owner, 2);

    // Backpressure in the middle of owner 1's burst.
    clear_reqs();
    do_reset();
    remaining[1] = BIG;
    remaining[2] = BIG;
    wait_writes(2);
    wfull = 1'b1;
    step(5);
    check("bp_no_write_stall", log_q.size(), 2);
    check("bp_busy", busy, 1);
    check("bp_owner", owner, 1);
    wfull = 1'b0;
    step(12);
    if (log_q.size() >= 5) begin
      check("bp_w2_who", log_q[2].who, 1);
      check("bp_w3_who", log_q[3].who, 1);
      check("bp_w4_who", log_q[4].who, 2);
      check("bp_stall_gap", log_q[2].cyc - log_q[1].cyc, 6);
      check("bp_rot_gap", log_q[4].cyc - log_q[3].cyc, 2);
    end else begin
      check("bp_enough_writes", log_q.size(), 5);
    end

    // Early drain by owner 3; requester 0 must win next.
    clear_reqs();
    do_reset();
    remaining[3] = 1;
    wait_writes(1);
    step(1);
    remaining[0] = 2;
    remaining[3] = 2;
    step(8);
    check("drain_count", log_q.size(), 5);
    if (log_q.size() >= 4) begin
      check("drain_w0_who", log_q[0].who, 3);
      check("drain_w1_who", log_q[1].who, 0);
      check("drain_gap", log_q[1].cyc - log_q[0].cyc, 3);
      check("drain_w3_who", log_q[3].who, 3);
    end

    // Reset in the middle of owner 2's burst.
    clear_reqs();
    do_reset();
    remaining[2] = BIG;
    wait_writes(2);
    c_in = log_q.size();
    remaining[0] = BIG;
    d0 = dat[0];
    wrst = 1'b1;
    step(1);
    wrst = 1'b0;
    check("rst_mid_no_write", log_q.size(), c_in);
    step(4);
    if (log_q.size() >= 3) begin
      check("rst_mid_next_who", log_q[2].who, 0);
      check("rst_mid_next_data", log_q[2].d, d0);
      check("rst_mid_gap", log_q[2].cyc - log_q[1].cyc, 3);
    end else begin
      check("rst_mid_enough_writes", log_q.size(), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
